// File: rtl/sha1_sequencer_if.sv
// SHA-1 sequencer stream interface.
// Message words in, 160-bit digest out.
interface sha1_sequencer_if;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [159:0] digest;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, digest, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, digest, out_valid
  );
endinterface

// File: rtl/sha1_sequencer.sv
// SHA-1 block sequencer: buffers 16 words,
// drives 80 rounds into a core, folds result.
module sha1_sequencer #(
  parameter int unsigned  CORE_LAT = 5,
  parameter logic [159:0] IV =
    160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0
) (
  input  logic            clk,
  input  logic            rst,
  sha1_sequencer_if.slave io,
  output logic [31:0]     core_din,
  output logic            core_load,
  output logic            core_phase_advance,
  input  logic [1:0]      core_phase_out,
  input  logic [31:0]     core_r,
  output logic            phase_err
);

  typedef enum logic [1:0] {
    FILL, RUN, DRAIN, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem_q [16];
  logic [3:0]      fcnt_q;
  logic [6:0]      rnd_q;
  logic [7:0]      dcnt_q;
  logic [4:0]      tag_q [CORE_LAT];
  logic [4:0]      tag_d;
  logic [4:0]      hit;
  logic [4:0][31:0] cap_q, cap_d;
  logic [159:0]    digest_q;
  logic            acc, hs;
  logic            run, drain, last_drain;

  function automatic logic [31:0] rol30(
    input logic [31:0] x
  );
    return {x[1:0], x[31:2]};
  endfunction

  assign run        = state_q == RUN;
  assign drain      = state_q == DRAIN;
  assign acc        = io.in_valid && io.in_ready;
  assign hs         = io.out_valid && io.out_ready;
  assign last_drain = drain &&
                      (dcnt_q == 8'(CORE_LAT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:
        if (acc && fcnt_q == 4'd15)
          state_d = RUN;
      RUN:
        if (rnd_q == 7'd79)
          state_d = DRAIN;
      DRAIN:
        if (last_drain)
          state_d = DONE;
      DONE:
        if (io.out_ready)
          state_d = FILL;
      default:
        state_d = FILL;
    endcase
  end

  // Handshake and core strobes.
  always_comb begin
    io.in_ready  = state_q == FILL;
    io.out_valid = state_q == DONE;
    io.digest    = digest_q;
    core_load    = run && (rnd_q < 7'd16);
    core_din     = core_load ?
                   mem_q[rnd_q[3:0]] : '0;
    core_phase_advance = run && (
      rnd_q == 7'd0  || rnd_q == 7'd20 ||
      rnd_q == 7'd40 || rnd_q == 7'd60);
  end

  // Tag rounds 75..79 and pick core_r when
  // each tag emerges CORE_LAT cycles later.
  always_comb begin
    tag_d = '0;
    if (run && rnd_q >= 7'd75)
      tag_d = 5'b00001 << (rnd_q - 7'd75);
    hit = tag_q[CORE_LAT-1];
    for (int k = 0; k < 5; k++)
      cap_d[k] = hit[k] ? core_r : cap_q[k];
  end

  // Capture tag delay line, cleared on reset so
  // an abandoned block leaves nothing in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CORE_LAT; i++)
        tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < CORE_LAT; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  // Block buffer write; contents need no reset.
  always_ff @(posedge clk) begin
    if (acc) mem_q[fcnt_q] <= io.in_data;
  end

  // Counters, captures, digest and phase check.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q    <= '0;
      rnd_q     <= '0;
      dcnt_q    <= '0;
      cap_q     <= '0;
      digest_q  <= '0;
      phase_err <= 1'b0;
    end else begin
      if (hs)
        fcnt_q <= '0;
      else if (acc)
        fcnt_q <= fcnt_q + 4'd1;
      rnd_q <= (run && rnd_q != 7'd79) ?
               rnd_q + 7'd1 : '0;
      dcnt_q <= drain ? dcnt_q + 8'd1 : '0;
      cap_q  <= cap_d;
      if (drain && dcnt_q == 8'd0 &&
          core_phase_out != 2'd3)
        phase_err <= 1'b1;
      if (last_drain)
        digest_q <= {
          IV[159:128] + cap_d[4],
          IV[127:96]  + cap_d[3],
          IV[95:64]   + rol30(cap_d[2]),
          IV[63:32]   + rol30(cap_d[1]),
          IV[31:0]    + rol30(cap_d[0])
        };
    end
  end

endmodule

// File: tb/tb_sha1_sequencer.sv
// Bench for sha1_sequencer with a behavioural
// SHA-1 round core and a digest scoreboard.
module tb_sha1_sequencer;
  localparam int LAT = 5;
  localparam logic [159:0] IV =
    160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] ABC_DIG =
    160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

  logic        clk = 0;
  logic        rst;
  logic [31:0] core_din;
  logic        core_load;
  logic        core_phase_advance;
  logic [1:0]  core_phase_out;
  logic [31:0] core_r;
  logic        phase_err;

  sha1_sequencer_if io ();

  sha1_sequencer #(.CORE_LAT(LAT), .IV(IV)) dut (
    .clk                (clk),
    .rst                (rst),
    .io                 (io),
    .core_din           (core_din),
    .core_load          (core_load),
    .core_phase_advance (core_phase_advance),
    .core_phase_out     (core_phase_out),
    .core_r             (core_r),
    .phase_err          (phase_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm,
                       input logic [159:0] act,
                       input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  // Behavioural core: one round per cycle,
  // A result delayed by LAT cycles.
  logic [31:0] ma, mb, mc, md, me;
  logic [1:0]  mph;
  int          mr;
  logic [31:0] mw [16];
  logic [31:0] mpipe [LAT];
  logic        force_ph2 = 0;

  assign core_r = mpipe[LAT-1];
  assign core_phase_out = force_ph2 ? 2'd2 : mph;

  always @(posedge clk) begin : core_model
    logic [31:0] a, b, c, d, e, wt, f, k, t;
    logic [1:0]  p;
    int          r;
    if (core_load && core_phase_advance) begin
      {a, b, c, d, e} = IV;
      r = 0;
      p = 2'd0;
    end else begin
      a = ma; b = mb; c = mc; d = md; e = me;
      r = mr;
      p = core_phase_advance ? mph + 2'd1 : mph;
    end
    if (core_load) wt = core_din;
    else begin
      wt = mw[(r-3)&15] ^ mw[(r-8)&15] ^
           mw[(r-14)&15] ^ mw[r&15];
      wt = {wt[30:0], wt[31]};
    end
    case (p)
      2'd0: begin
        f = (b & c) | (~b & d);
        k = 32'h5a827999;
      end
      2'd1: begin
        f = b ^ c ^ d;
        k = 32'h6ed9eba1;
      end
      2'd2: begin
        f = (b & c) | (b & d) | (c & d);
        k = 32'h8f1bbcdc;
      end
      default: begin
        f = b ^ c ^ d;
        k = 32'hca62c1d6;
      end
    endcase
    t = {a[26:0], a[31:27]} + f + e + k + wt;
    mw[r&15] <= wt;
    ma <= t;
    mb <= a;
    mc <= {b[1:0], b[31:2]};
    md <= c;
    me <= d;
    mr <= r + 1;
    mph <= p;
    mpipe[0] <= t;
    for (int i = 1; i < LAT; i++)
      mpipe[i] <= mpipe[i-1];
  end

  // Scoreboard and monitor state.
  logic [159:0] exp_q[$];
  int           t_acc = 0;
  logic         ov_prev = 0;
  logic [159:0] held;
  logic         started = 0;
  int           st = 0;
  logic [127:0] load_bits, adv_bits;
  logic [127:0] exp_load, exp_adv;

  initial begin
    exp_load = '0;
    for (int i = 0; i < 16; i++)
      exp_load[i] = 1'b1;
    exp_adv = '0;
    exp_adv[0] = 1'b1;
    exp_adv[20] = 1'b1;
    exp_adv[40] = 1'b1;
    exp_adv[60] = 1'b1;
  end

  // Monitor: strobes, stall stability, digests.
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 0;
    end else begin
      if (core_load && core_phase_advance) begin
        started = 1;
        st = cyc;
        load_bits = '0;
        adv_bits = '0;
      end
      if (started && cyc - st < 128) begin
        if (core_load) load_bits[cyc-st] = 1'b1;
        if (core_phase_advance)
          adv_bits[cyc-st] = 1'b1;
      end
      if (core_phase_advance)
        check("in_ready_run", io.in_ready, 0);
      if (io.out_valid) begin
        check("in_ready_done", io.in_ready, 0);
        if (!ov_prev) begin
          held = io.digest;
          check("ov_latency", cyc - t_acc, 81 + LAT);
          check("load_rounds", load_bits, exp_load);
          check("adv_rounds", adv_bits, exp_adv);
        end else begin
          check("digest_hold", io.digest, held);
        end
        if (io.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ov: got %h want none",
                     io.digest);
          end else begin
            check("digest", io.digest, exp_q.pop_front());
          end
        end
      end
      ov_prev = io.out_valid && !io.out_ready;
    end
  end

  logic [31:0] abc [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input int gap);
    for (int i = 0; i < 16; i++) begin
      int  budget = 0;
      bit  took = 0;
      int  tcur;
      io.in_data = abc[i];
      io.in_valid = 1;
      while (!took && budget < 300) begin
        took = io.in_ready;
        tcur = cyc;
        tick();
        budget++;
      end
      if (!took) begin
        check("accept_timeout", 0, 1);
        io.in_valid = 0;
        return;
      end
      if (i == 15) t_acc = tcur;
      if (gap > 0 || i == 15) begin
        io.in_valid = 0;
        repeat (gap) tick();
      end
    end
  endtask

  task automatic wait_done();
    int b = 0;
    while (exp_q.size() != 0 && b < 300) begin
      tick();
      b++;
    end
    check("done_in_time", exp_q.size() == 0, 1);
    exp_q.delete();
  endtask

  task automatic pulse_rst();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    bit seen;
    int b;
    for (int i = 0; i < 16; i++) abc[i] = '0;
    abc[0] = 32'h61626380;
    abc[15] = 32'h00000018;
    io.in_data = '0;
    io.in_valid = 0;
    io.out_ready = 1;
    rst = 1;
    tick();
    tick();
    rst = 0;

    check("rst_in_ready", io.in_ready, 1);
    check("rst_out_valid", io.out_valid, 0);
    check("rst_digest", io.digest, 0);
    check("rst_core_load", core_load, 0);
    check("rst_adv", core_phase_advance, 0);
    check("rst_phase_err", phase_err, 0);

    exp_q.push_back(ABC_DIG);
    send_block(0);
    wait_done();

    exp_q.push_back(ABC_DIG);
    send_block(3);
    wait_done();

    io.out_ready = 0;
    exp_q.push_back(ABC_DIG);
    send_block(0);
    b = 0;
    while (!io.out_valid && b < 300) begin
      tick();
      b++;
    end
    check("stall_ov_seen", io.out_valid, 1);
    repeat (10) tick();
    io.out_ready = 1;
    tick();
    check("fill_after_hs", io.in_ready, 1);
    check("ov_after_hs", io.out_valid, 0);
    wait_done();

    send_block(0);
    repeat (40) tick();
    pulse_rst();
    check("abort_in_ready", io.in_ready, 1);
    check("abort_digest", io.digest, 0);
    check("abort_core_load", core_load, 0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (io.out_valid) seen = 1;
      tick();
    end
    check("abort_no_ov", seen, 0);

    exp_q.push_back(ABC_DIG);
    send_block(0);
    wait_done();
    check("no_phase_err", phase_err, 0);

    force_ph2 = 1;
    exp_q.push_back(ABC_DIG);
    send_block(0);
    wait_done();
    force_ph2 = 0;
    check("phase_err_set", phase_err, 1);
    exp_q.push_back(ABC_DIG);
    send_block(0);
    wait_done();
    check("phase_err_sticky", phase_err, 1);
    pulse_rst();
    check("phase_err_clr", phase_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
